// File: rtl/oled_frame_streamer.sv
// SSD1306 frame sequencer: addressing preamble, then frame-buffer bytes,
// one byte per spi_tx start/done handshake with cs_n/dc ownership.
module oled_frame_streamer #(
  parameter int BitCount   = 8,
  parameter int PixelBytes = 1024,
  parameter int AddrWidth  = 10
) (
  input  logic                 sclk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic [AddrWidth-1:0] fb_addr,
  output logic                 fb_rd,
  input  logic [BitCount-1:0]  fb_data,
  output logic [BitCount-1:0]  tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 dc,
  output logic                 cs_n
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_SEND,
    CMD_WAIT,
    PIX_FETCH,
    PIX_SEND,
    PIX_WAIT,
    FINISH
  } state_t;

  localparam logic [AddrWidth-1:0] LastAddr =
    AddrWidth'(PixelBytes - 1);
  localparam logic [2:0] LastCmd = 3'd5;

  state_t              state;
  logic [2:0]          idx;
  logic [BitCount-1:0] tx_q;

  function automatic logic [BitCount-1:0] rom(
    input logic [2:0] i
  );
    logic [BitCount-1:0] b;
    b = '0;
    unique case (i)
      3'd0:    b = BitCount'(8'h21);
      3'd1:    b = BitCount'(8'h00);
      3'd2:    b = BitCount'(8'h7F);
      3'd3:    b = BitCount'(8'h22);
      3'd4:    b = BitCount'(8'h00);
      3'd5:    b = BitCount'(8'h07);
      default: b = '0;
    endcase
    return b;
  endfunction

  // Read data arrives during PIX_SEND, so present it directly that cycle.
  assign tx_data = (state == PIX_SEND) ? fb_data : tx_q;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      tx_q       <= '0;
      tx_start   <= 1'b0;
      fb_rd      <= 1'b0;
      fb_addr    <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      dc         <= 1'b0;
      cs_n       <= 1'b1;
    end else begin
      tx_start   <= 1'b0;
      fb_rd      <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start && !tx_busy) begin
            state      <= CMD_SEND;
            idx        <= '0;
            cs_n       <= 1'b0;
            dc         <= 1'b0;
            frame_busy <= 1'b1;
            tx_start   <= 1'b1;
            tx_q       <= rom(3'd0);
          end
        end
        CMD_SEND: state <= CMD_WAIT;
        CMD_WAIT: begin
          if (tx_done) begin
            if (idx == LastCmd) begin
              fb_addr <= '0;
              fb_rd   <= 1'b1;
              state   <= PIX_FETCH;
            end else begin
              idx      <= idx + 3'd1;
              tx_start <= 1'b1;
              tx_q     <= rom(idx + 3'd1);
              state    <= CMD_SEND;
            end
          end
        end
        PIX_FETCH: begin
          dc       <= 1'b1;
          tx_start <= 1'b1;
          state    <= PIX_SEND;
        end
        PIX_SEND: begin
          tx_q  <= fb_data;
          state <= PIX_WAIT;
        end
        PIX_WAIT: begin
          if (tx_done) begin
            if (fb_addr != LastAddr) begin
              fb_addr <= fb_addr + 1'b1;
              fb_rd   <= 1'b1;
              state   <= PIX_FETCH;
            end else begin
              frame_done <= 1'b1;
              state      <= FINISH;
            end
          end
        end
        FINISH: begin
          cs_n       <= 1'b1;
          dc         <= 1'b0;
          fb_addr    <= '0;
          frame_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer: spi_tx and frame-buffer models,
// byte-stream reference built from the command list and buffer contents.
module tb_oled_frame_streamer;

  localparam int PB = 4;
  localparam int AW = 2;
  localparam int BC = 8;

  logic          sclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_busy, frame_done;
  logic [AW-1:0] fb_addr;
  logic          fb_rd;
  logic [BC-1:0] fb_data = '0;
  logic [BC-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy, tx_done;
  logic          dc, cs_n;

  logic m_busy = 1'b0, m_done = 1'b0;
  logic inj_busy = 1'b0, inj_done = 1'b0;
  logic fix_lat = 1'b1;
  int   cnt = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [PB];
  logic [7:0] rom_ref [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  assign tx_busy = m_busy | inj_busy;
  assign tx_done = m_done | inj_done;

  always #5 sclk = ~sclk;

  oled_frame_streamer #(
    .BitCount(BC), .PixelBytes(PB), .AddrWidth(AW)
  ) dut (
    .sclk(sclk), .reset_n(reset_n), .frame_start(frame_start),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
    .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .dc(dc), .cs_n(cs_n)
  );

  always @(posedge sclk)
    if (fb_rd) fb_data <= mem[fb_addr];

  always @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (tx_start) begin
        cnt    <= fix_lat ? 5 : int'($urandom_range(6, 1));
        m_busy <= 1'b1;
      end
    end
  end

  logic [8:0] obs_q [$];
  int         rd_q [$];
  int         gap_q [$];
  int         n_start = 0, n_done = 0, viol = 0, run = 0;
  logic       prev_start = 1'b0, prev_rd = 1'b0, hold = 1'b0;
  logic [8:0] hold_val = '0;

  always @(negedge sclk) begin
    if (!reset_n) begin
      prev_start <= 1'b0;
      prev_rd    <= 1'b0;
      hold       <= 1'b0;
    end else begin
      if (tx_start) begin
        obs_q.push_back({dc, tx_data});
        n_start  <= n_start + 1;
        hold     <= 1'b1;
        hold_val <= {dc, tx_data};
        if (prev_start || cs_n || hold) viol <= viol + 1;
      end else if (hold && {dc, tx_data} != hold_val) begin
        viol <= viol + 1;
      end
      if (m_done) hold <= 1'b0;
      if (fb_rd) begin
        rd_q.push_back(int'(fb_addr));
        if (prev_rd || tx_start) viol <= viol + 1;
      end
      if (frame_busy == cs_n) viol <= viol + 1;
      if (frame_done) n_done <= n_done + 1;
      if (cs_n) run <= run + 1;
      else if (run > 0) begin
        gap_q.push_back(run);
        run <= 0;
      end
      prev_start <= tx_start;
      prev_rd    <= fb_rd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  function automatic logic [8:0] exp_byte(input int i);
    if (i < 6) return {1'b0, rom_ref[i]};
    return {1'b1, mem[i-6]};
  endfunction

  task automatic rand_mem();
    for (int a = 0; a < PB; a++) mem[a] = 8'($urandom);
  endtask

  task automatic wait_frames(input int n);
    int seen = 0;
    int k = 0;
    while (seen < n && k < 3000) begin
      @(negedge sclk);
      k++;
      if (frame_done) seen++;
    end
    frame_start = 1'b0;
    chk("frame_timeout", seen, n);
  endtask

  task automatic cmp_frame(input string tag, input int ob, input int rb);
    for (int i = 0; i < 6 + PB; i++)
      chk($sformatf("%s_byte%0d", tag, i),
          (ob + i < obs_q.size()) ? 32'(obs_q[ob+i]) : 32'hdead,
          32'(exp_byte(i)));
    for (int a = 0; a < PB; a++)
      chk($sformatf("%s_addr%0d", tag, a),
          (rb + a < rd_q.size()) ? rd_q[rb+a] : -1, a);
  endtask

  task automatic single_frame(input string tag);
    int ob = obs_q.size();
    int rb = rd_q.size();
    int s0 = n_start;
    int d0 = n_done;
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    wait_frames(1);
    cyc(3);
    chk({tag, "_starts"}, n_start - s0, 6 + PB);
    chk({tag, "_dones"}, n_done - d0, 1);
    cmp_frame(tag, ob, rb);
    chk({tag, "_csn_end"}, cs_n, 1);
  endtask

  initial begin
    int ob, rb, s0, d0, gb, k;
    for (int a = 0; a < PB; a++) mem[a] = 8'hA0 + 8'(a);

    cyc(3);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_dc", dc, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_fb_rd", fb_rd, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_done", frame_done, 0);
    reset_n = 1'b1;
    cyc(10);
    chk("idle_starts", n_start, 0);
    chk("idle_cs_n", cs_n, 1);

    // full frame, fixed 5-cycle spi latency, addr+0xA0 contents
    ob = obs_q.size(); rb = rd_q.size(); s0 = n_start; d0 = n_done;
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("accept_cs_n", cs_n, 0);
    chk("accept_busy", frame_busy, 1);
    chk("accept_tx_start", tx_start, 1);
    wait_frames(1);
    cyc(3);
    chk("full_starts", n_start - s0, 10);
    chk("full_dones", n_done - d0, 1);
    cmp_frame("full", ob, rb);
    chk("full_csn_end", cs_n, 1);

    // frame_start pulsed during pixel byte 2
    fix_lat = 1'b0;
    rand_mem();
    ob = obs_q.size(); rb = rd_q.size(); s0 = n_start; d0 = n_done;
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    k = 0;
    while (n_start < s0 + 9 && k < 500) begin
      cyc(1);
      k++;
    end
    chk("bi_reach_pix2", k < 500, 1);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    wait_frames(1);
    cyc(30);
    chk("bi_starts", n_start - s0, 10);
    chk("bi_dones", n_done - d0, 1);
    cmp_frame("bi", ob, rb);

    // spurious done in IDLE and in CMD_SEND
    s0 = n_start;
    inj_done = 1'b1;
    cyc(1);
    inj_done = 1'b0;
    cyc(3);
    chk("sp_idle_starts", n_start - s0, 0);
    chk("sp_idle_busy", frame_busy, 0);
    chk("sp_idle_cs_n", cs_n, 1);
    rand_mem();
    ob = obs_q.size(); rb = rd_q.size(); s0 = n_start; d0 = n_done;
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("sp_in_cmd_send", tx_start, 1);
    inj_done = 1'b1;
    cyc(1);
    inj_done = 1'b0;
    wait_frames(1);
    cyc(3);
    chk("sp_starts", n_start - s0, 10);
    cmp_frame("sp", ob, rb);

    // start refused while spi_tx reports busy
    s0 = n_start;
    inj_busy = 1'b1;
    frame_start = 1'b1;
    cyc(5);
    chk("tb_hold_starts", n_start - s0, 0);
    chk("tb_hold_cs_n", cs_n, 1);
    chk("tb_hold_busy", frame_busy, 0);
    rand_mem();
    ob = obs_q.size(); rb = rd_q.size(); d0 = n_done;
    inj_busy = 1'b0;
    cyc(1);
    frame_start = 1'b0;
    wait_frames(1);
    cyc(3);
    chk("tb_starts", n_start - s0, 10);
    cmp_frame("tb", ob, rb);

    // asynchronous reset while 0x22 is being started
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    k = 0;
    while (!(tx_start && tx_data == 8'h22) && k < 500) begin
      cyc(1);
      k++;
    end
    chk("mr_reach_0x22", k < 500, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_cs_n", cs_n, 1);
    chk("mr_tx_start", tx_start, 0);
    chk("mr_busy", frame_busy, 0);
    chk("mr_dc", dc, 0);
    chk("mr_tx_data", tx_data, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    rand_mem();
    single_frame("mr_after");

    for (int r = 0; r < 3; r++) begin
      rand_mem();
      single_frame($sformatf("rnd%0d", r));
    end

    // back-to-back frames with frame_start held high
    rand_mem();
    ob = obs_q.size(); rb = rd_q.size(); s0 = n_start; d0 = n_done;
    gb = gap_q.size();
    frame_start = 1'b1;
    wait_frames(2);
    cyc(30);
    chk("b2b_starts", n_start - s0, 20);
    chk("b2b_dones", n_done - d0, 2);
    cmp_frame("b2b_f0", ob, rb);
    cmp_frame("b2b_f1", ob + 10, rb + PB);
    chk("b2b_gap", (gb + 1 < gap_q.size()) ? gap_q[gb+1] : -1, 1);

    chk("rules", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
